// File: rtl/dsp_ctrl_pkg.sv
// Shared constants and types for the DSP48A1 MAC sequencer.
// Ports: none (package). Holds OPMODE encodings, FSM state enum and datapath widths.
// Latency/backpressure: n/a.
package dsp_ctrl_pkg;

   localparam int ACC_W = 48;   // slice P / result width
   localparam int IN_W  = 18;   // slice A/B operand width

   // X mux = M, Z mux = 0: start a fresh sum with the first product
   localparam logic [7:0] OPM_MUL = 8'h01;
   // X mux = M, Z mux = P: accumulate onto the running sum
   localparam logic [7:0] OPM_MAC = 8'h09;

   typedef enum logic [2:0] {
      CLEAR,
      IDLE,
      FEED,
      DRAIN,
      HOLD
   } state_t;

endpackage

// File: rtl/dsp_mac_ctrl_opmode_delay.sv
// CE-gated shift register that delays each OPMODE tag until its product reaches the slice M stage.
// Ports: clk_i, rst_i (sync clear), ce_i (shift enable), din_i (tag in), dout_o (tail).
// Latency: DEPTH CE-enabled edges; holds contents when ce_i is low.
module opmode_delay
#(
   parameter int DEPTH = 2
)(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ce_i,
   input  logic [7:0] din_i,
   output logic [7:0] dout_o
);

   logic [7:0] sr_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            sr_q[i] <= 8'h00;
         end
      end else if (ce_i) begin
         sr_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) begin
            sr_q[i] <= sr_q[i-1];
         end
      end
   end

   assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_ctrl.sv
// Sequencer feeding a DSP48A1 slice to compute an N_TAPS-term signed dot product.
// Ports: clk/RST; s_valid/s_ready/s_a/s_b pair input; dsp_* slice drive and dsp_P return;
//        m_valid/m_ready/m_data result. Last pair to m_valid: PIPE_LAT+1 edges; s_ready low outside IDLE/FEED.
module dsp_mac_ctrl
   import dsp_ctrl_pkg::*;
#(
   parameter int N_TAPS     = 8,
   parameter int PIPE_LAT   = 4,
   parameter int OPMODE_DLY = 2,
   parameter int CLR_CYC    = 2
)(
   input  logic             clk,
   input  logic             RST,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [IN_W-1:0]  s_a,
   input  logic [IN_W-1:0]  s_b,
   output logic [IN_W-1:0]  dsp_A,
   output logic [IN_W-1:0]  dsp_B,
   output logic [7:0]       dsp_OPMODE,
   output logic             dsp_CE,
   output logic             dsp_RST,
   input  logic [ACC_W-1:0] dsp_P,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [ACC_W-1:0] m_data
);

   localparam logic [8:0] LAST_TAP   = 9'(N_TAPS - 1);
   localparam logic [7:0] CLR_LAST   = 8'(CLR_CYC - 1);
   localparam logic [7:0] DRAIN_LAST = 8'(PIPE_LAT);

   state_t            state_q, state_d;
   logic [8:0]        tap_q, tap_d;
   logic [7:0]        cnt_q, cnt_d;      // CLEAR / DRAIN cycle counter
   logic              s_ready_q, s_ready_d;
   logic              m_valid_q, m_valid_d;
   logic [ACC_W-1:0]  m_data_q, m_data_d;
   logic [IN_W-1:0]   a_q, a_d, b_q, b_d;
   logic              ce_q, ce_d;
   logic              dsp_rst_q, dsp_rst_d;
   // OPMODE tag registered alongside dsp_A/dsp_B; it enters the delay line on the
   // same CE-enabled edge on which the slice A0 register takes the operands, so
   // tag and product advance in lockstep through any stalls.
   logic [7:0]        op_q, op_d;
   logic              accept;

   assign accept = s_valid & s_ready_q;

   always_comb begin
      state_d   = state_q;
      tap_d     = tap_q;
      cnt_d     = cnt_q;
      s_ready_d = 1'b0;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      a_d       = a_q;
      b_d       = b_q;
      ce_d      = 1'b0;
      dsp_rst_d = 1'b0;
      op_d      = op_q;

      unique case (state_q)
         CLEAR: begin
            dsp_rst_d = 1'b1;
            cnt_d     = cnt_q + 8'd1;
            if (cnt_q == CLR_LAST) begin
               state_d   = IDLE;
               dsp_rst_d = 1'b0;
               s_ready_d = 1'b1;
               cnt_d     = 8'd0;
            end
         end

         IDLE, FEED: begin
            s_ready_d = 1'b1;
            if (accept) begin
               a_d   = s_a;
               b_d   = s_b;
               ce_d  = 1'b1;
               op_d  = (state_q == IDLE) ? OPM_MUL : OPM_MAC;
               tap_d = (state_q == IDLE) ? 9'd1 : tap_q + 9'd1;
               state_d = FEED;
               // tap_q counts pairs already taken; this accept is the last one
               if (tap_q == LAST_TAP) begin
                  state_d   = DRAIN;
                  s_ready_d = 1'b0;
                  cnt_d     = 8'd0;
               end
            end
         end

         DRAIN: begin
            // zero operands keep the slice clocking until the last product lands in P
            a_d   = '0;
            b_d   = '0;
            op_d  = OPM_MAC;
            ce_d  = 1'b1;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == DRAIN_LAST) begin
               m_data_d  = dsp_P;
               m_valid_d = 1'b1;
               ce_d      = 1'b0;
               state_d   = HOLD;
            end
         end

         HOLD: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               s_ready_d = 1'b1;
               tap_d     = 9'd0;
               state_d   = IDLE;
            end
         end

         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q   <= CLEAR;
         tap_q     <= 9'd0;
         cnt_q     <= 8'd0;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         a_q       <= '0;
         b_q       <= '0;
         ce_q      <= 1'b0;
         dsp_rst_q <= 1'b1;
         op_q      <= 8'h00;
      end else begin
         state_q   <= state_d;
         tap_q     <= tap_d;
         cnt_q     <= cnt_d;
         s_ready_q <= s_ready_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         a_q       <= a_d;
         b_q       <= b_d;
         ce_q      <= ce_d;
         dsp_rst_q <= dsp_rst_d;
         op_q      <= op_d;
      end
   end

   // shifts on the same edges the slice pipeline advances (slice CE high)
   opmode_delay #(
      .DEPTH (OPMODE_DLY)
   ) u_opmode_delay (
      .clk_i  (clk),
      .rst_i  (RST),
      .ce_i   (ce_q),
      .din_i  (op_q),
      .dout_o (dsp_OPMODE)
   );

   assign s_ready = s_ready_q;
   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign dsp_A   = a_q;
   assign dsp_B   = b_q;
   assign dsp_CE  = ce_q;
   assign dsp_RST = dsp_rst_q;

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// Bench for dsp_mac_ctrl driving a behavioural DSP48A1 slice (A0, A1, M, OPMODE and P
// registers all enabled, shared CE/RST). Expected results go into a scoreboard queue;
// a monitor checks m_valid rise cycle and popped m_data on each handshake.
module tb_dsp_mac_ctrl;

   localparam int NT = 4;

   logic        clk = 1'b0;
   logic        RST;
   logic        s_valid;
   logic        s_ready;
   logic [17:0] s_a, s_b;
   logic [17:0] dsp_A, dsp_B;
   logic [7:0]  dsp_OPMODE;
   logic        dsp_CE, dsp_RST;
   logic [47:0] dsp_P;
   logic        m_valid, m_ready;
   logic [47:0] m_data;

   always #5 clk = ~clk;

   dsp_mac_ctrl #(
      .N_TAPS     (NT),
      .PIPE_LAT   (4),
      .OPMODE_DLY (2),
      .CLR_CYC    (2)
   ) dut (
      .clk        (clk),
      .RST        (RST),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_a        (s_a),
      .s_b        (s_b),
      .dsp_A      (dsp_A),
      .dsp_B      (dsp_B),
      .dsp_OPMODE (dsp_OPMODE),
      .dsp_CE     (dsp_CE),
      .dsp_RST    (dsp_RST),
      .dsp_P      (dsp_P),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data)
   );

   // ---------------- behavioural slice ----------------
   logic signed [17:0] a0, b0, a1, b1;
   logic signed [35:0] mreg;
   logic [7:0]         opm_r;
   logic [47:0]        preg;
   logic [47:0]        xmux, zmux;

   assign xmux  = (opm_r[1:0] == 2'b01) ? {{12{mreg[35]}}, mreg} : 48'd0;
   assign zmux  = (opm_r[3:2] == 2'b10) ? preg : 48'd0;
   assign dsp_P = preg;

   always @(posedge clk) begin
      if (dsp_RST) begin
         a0 <= '0; b0 <= '0; a1 <= '0; b1 <= '0;
         mreg <= '0; opm_r <= '0; preg <= '0;
      end else if (dsp_CE) begin
         a0    <= dsp_A;
         b0    <= dsp_B;
         a1    <= a0;
         b1    <= b0;
         mreg  <= a1 * b1;
         opm_r <= dsp_OPMODE;
         preg  <= xmux + zmux;
      end
   end

   // ---------------- bookkeeping ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0]  opm_tr [0:4095];
   logic [17:0] a_tr   [0:4095];
   always @(negedge clk) begin
      if (cyc < 4096) begin
         opm_tr[cyc] = dsp_OPMODE;
         a_tr[cyc]   = dsp_A;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [47:0] data;
      int          rise;
   } exp_t;
   exp_t sb[$];

   // ---------------- monitor ----------------
   logic mv_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (m_valid && !mv_prev) begin
         if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_valid: m_data=%h at cycle %0d with no expected entry", m_data, cyc);
         end else begin
            check("m_valid_rise_cycle", 64'(cyc), 64'(sb[0].rise));
         end
      end
      if (m_valid && m_ready && sb.size() != 0) begin
         e = sb.pop_front();
         check("m_data", m_data, {16'd0, e.data});
      end
      mv_prev = m_valid;
   end

   // ---------------- driver ----------------
   int va [NT];
   int vb [NT];

   task automatic send_pair(input int a, input int b, output int acc);
      int w = 0;
      s_valid = 1'b1;
      s_a = 18'(a);
      s_b = 18'(b);
      while (!s_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      if (!s_ready) check("s_ready_wait", 64'(s_ready), 64'd1);
      @(posedge clk); #1;
      acc = cyc;
      s_valid = 1'b0;
   endtask

   // stall_after: pair index after which s_valid drops for stall_len cycles (-1 = none)
   task automatic run_dot(input int stall_after, input int stall_len,
                          input logic [47:0] exp, output int first);
      int acc;
      int stalls = 0;
      first = 0;
      for (int i = 0; i < NT; i++) begin
         send_pair(va[i], vb[i], acc);
         if (i == 0) first = acc;
         if (i == stall_after && i < NT - 1) begin
            stalls = stall_len;
            for (int k = 0; k < stall_len; k++) begin
               @(posedge clk); #1;
               check("stall_dsp_CE", 64'(dsp_CE), 64'd0);
            end
         end
      end
      // (NT-1) back-to-back accepts, then PIPE_LAT+1 edges to m_valid
      sb.push_back('{data: exp, rise: first + (NT - 1) + 5 + stalls});
   endtask

   task automatic wait_drain();
      int w = 0;
      while ((sb.size() != 0 || m_valid) && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      if (sb.size() != 0) check("result_timeout", 64'(sb.size()), 64'd0);
   endtask

   int f1, fx;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready",  64'(s_ready),    64'd0);
      check("rst_m_valid",  64'(m_valid),    64'd0);
      check("rst_m_data",   64'(m_data),     64'd0);
      check("rst_dsp_A",    64'(dsp_A),      64'd0);
      check("rst_dsp_B",    64'(dsp_B),      64'd0);
      check("rst_opmode",   64'(dsp_OPMODE), 64'd0);
      check("rst_dsp_CE",   64'(dsp_CE),     64'd0);
      check("rst_dsp_RST",  64'(dsp_RST),    64'd1);
      RST = 1'b0;
      @(posedge clk); #1;
      check("clr1_dsp_RST", 64'(dsp_RST), 64'd1);
      check("clr1_s_ready", 64'(s_ready), 64'd0);
      @(posedge clk); #1;
      check("clr2_dsp_RST", 64'(dsp_RST), 64'd0);
      check("clr2_s_ready", 64'(s_ready), 64'd1);

      // basic dot product: 1*2+3*4+5*6+7*8 = 100
      va = '{1, 3, 5, 7}; vb = '{2, 4, 6, 8};
      run_dot(-1, 0, 48'd100, f1);
      wait_drain();
      check("dsp_A_first",  64'(a_tr[f1]),       64'd1);
      check("dsp_A_last",   64'(a_tr[f1 + 3]),   64'd7);
      check("opm_before",   64'(opm_tr[f1 + 1]), 64'h00);
      check("opm_0",        64'(opm_tr[f1 + 2]), 64'h01);
      check("opm_1",        64'(opm_tr[f1 + 3]), 64'h09);
      check("opm_2",        64'(opm_tr[f1 + 4]), 64'h09);
      check("opm_3",        64'(opm_tr[f1 + 5]), 64'h09);

      // signed mix: -15+2+0+1 = -12
      va = '{-3, 2, 0, -1}; vb = '{5, 1, 9, -1};
      run_dot(-1, 0, 48'hFFFF_FFFF_FFF4, fx);
      wait_drain();

      // most negative operands: 4 * 2^34 = 2^36
      va = '{-131072, -131072, -131072, -131072}; vb = '{-131072, -131072, -131072, -131072};
      run_dot(-1, 0, 48'h0010_0000_0000, fx);
      wait_drain();

      // 3-cycle input stall after the second pair
      va = '{1, 3, 5, 7}; vb = '{2, 4, 6, 8};
      run_dot(1, 3, 48'd100, fx);
      wait_drain();

      // result backpressure: hold for 5 cycles
      m_ready = 1'b0;
      run_dot(-1, 0, 48'd100, fx);
      begin
         int w = 0;
         while (!m_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
         end
      end
      for (int k = 0; k < 5; k++) begin
         check("hold_m_valid", 64'(m_valid), 64'd1);
         check("hold_m_data",  64'(m_data),  64'd100);
         check("hold_s_ready", 64'(s_ready), 64'd0);
         @(posedge clk); #1;
      end
      m_ready = 1'b1;
      wait_drain();

      va = '{1, 1, 1, 1}; vb = '{1, 1, 1, 1};
      run_dot(-1, 0, 48'd4, fx);
      wait_drain();

      // abort after two pairs
      begin
         int acc;
         send_pair(1, 2, acc);
         send_pair(3, 4, acc);
      end
      RST = 1'b1;
      @(posedge clk); #1;
      RST = 1'b0;
      check("abort_m_valid", 64'(m_valid), 64'd0);
      check("abort_dsp_RST", 64'(dsp_RST), 64'd1);
      check("abort_s_ready", 64'(s_ready), 64'd0);
      check("abort_dsp_CE",  64'(dsp_CE),  64'd0);
      va = '{1, 3, 5, 7}; vb = '{2, 4, 6, 8};
      run_dot(-1, 0, 48'd100, fx);
      wait_drain();

      repeat (10) @(posedge clk);
      #1;
      check("sb_empty_at_end", 64'(sb.size()), 64'd0);
      check("m_valid_idle_end", 64'(m_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
